// File: rtl/eh2_lsu_busm_arb_if.sv
// Command/response bundle between the per-thread bus buffers, the LSU bus
// master arbiter and the bus side. The master modport is the arbiter's view.
interface eh2_lsu_busm_arb_if #(
  parameter int unsigned NUM_THREADS = 2,
  parameter int unsigned TAGW        = 3
);
  logic [NUM_THREADS-1:0]           req_vld;
  logic [NUM_THREADS-1:0][TAGW-1:0] req_tag;
  logic [NUM_THREADS-1:0]           dec_tlu_force_halt_bus;
  logic                             busm_cmd_rdy;
  logic                             busm_rsp_vld;
  logic                             busm_rsp_tid;
  logic [NUM_THREADS-1:0]           req_gnt;
  logic                             busm_cmd_vld;
  logic                             busm_cmd_tid;
  logic [TAGW-1:0]                  busm_cmd_tag;
  logic                             busm_clken_req;
  logic [NUM_THREADS-1:0][2:0]      outs_cnt;

  modport master (
    input  req_vld, req_tag, dec_tlu_force_halt_bus, busm_cmd_rdy, busm_rsp_vld, busm_rsp_tid,
    output req_gnt, busm_cmd_vld, busm_cmd_tid, busm_cmd_tag, busm_clken_req, outs_cnt
  );

  modport slave (
    output req_vld, req_tag, dec_tlu_force_halt_bus, busm_cmd_rdy, busm_rsp_vld, busm_rsp_tid,
    input  req_gnt, busm_cmd_vld, busm_cmd_tid, busm_cmd_tag, busm_clken_req, outs_cnt
  );
endinterface

// File: rtl/eh2_lsu_busm_arb.sv
// LSU bus master command arbiter: picks one thread's bus-buffer command,
// holds it on the bus until accepted, and tracks per-thread outstanding
// commands. Optional build macro RV_LSU_BUSM_FIXED_PRIO_EN makes thread 0
// always win instead of round-robin.
module eh2_lsu_busm_arb #(
  parameter int unsigned NUM_THREADS = 2,
  parameter int unsigned TAGW        = 3,
  parameter int unsigned MAX_OUTS    = 4
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               lsu_bus_clk_en,
  eh2_lsu_busm_arb_if.master bus
);

  typedef enum logic [1:0] {StIdle, StCmd, StHalt} state_e;

  state_e                      state_q, state_d;
  logic                        tid_q, tid_d;
  logic [TAGW-1:0]             tag_q, tag_d;
  logic [NUM_THREADS-1:0][2:0] cnt_q, cnt_d;
  logic [NUM_THREADS-1:0]      gnt;

  // Thread-indexed views padded to two entries so one thread builds cleanly.
  logic [1:0]           req_pad, halt_pad, elig;
  logic [1:0][2:0]      cnt_pad;
  logic [1:0][TAGW-1:0] tag_pad;
  logic                 all_halt, accept, winner;

`ifndef RV_LSU_BUSM_FIXED_PRIO_EN
  logic ptr_q, ptr_d;
`endif

  // Pad per-thread inputs and derive eligibility.
  always_comb begin
    req_pad  = '0;
    halt_pad = '0;
    cnt_pad  = '0;
    tag_pad  = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      req_pad[t]  = bus.req_vld[t];
      halt_pad[t] = bus.dec_tlu_force_halt_bus[t];
      cnt_pad[t]  = cnt_q[t];
      tag_pad[t]  = bus.req_tag[t];
    end
    for (int unsigned t = 0; t < 2; t++) begin
      elig[t] = req_pad[t] & ~halt_pad[t] & (cnt_pad[t] < 3'(MAX_OUTS));
    end
    all_halt = &bus.dec_tlu_force_halt_bus;
  end

  // Winner selection.
  always_comb begin
`ifdef RV_LSU_BUSM_FIXED_PRIO_EN
    winner = ~elig[0];
`else
    winner = elig[ptr_q] ? ptr_q : ~ptr_q;
`endif
  end

  // FSM next state and command capture.
  always_comb begin
    state_d = state_q;
    tid_d   = tid_q;
    tag_d   = tag_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (all_halt) begin
          state_d = StHalt;
        end else if (lsu_bus_clk_en && (|elig)) begin
          state_d = StCmd;
          tid_d   = (NUM_THREADS > 1) ? winner : 1'b0;
          tag_d   = tag_pad[winner];
        end
      end
      StCmd: begin
        // Force halt does not withdraw a command already on the bus.
        if (lsu_bus_clk_en && bus.busm_cmd_rdy) begin
          accept  = 1'b1;
          state_d = StIdle;
        end
      end
      StHalt: begin
        if (!all_halt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Grant pulse; reset wins over an acceptance in the same cycle.
  always_comb begin
    gnt = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      gnt[t] = accept & rst_l & (tid_q == 1'(t));
    end
  end

  // Outstanding counters: simultaneous grant and response cancel out.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (gnt[t] && !(bus.busm_rsp_vld && lsu_bus_clk_en && (bus.busm_rsp_tid == 1'(t)))) begin
        cnt_d[t] = cnt_q[t] + 3'd1;
      end else if (!gnt[t] && bus.busm_rsp_vld && lsu_bus_clk_en &&
                   (bus.busm_rsp_tid == 1'(t)) && (cnt_q[t] != 3'd0)) begin
        cnt_d[t] = cnt_q[t] - 3'd1;
      end
    end
  end

`ifndef RV_LSU_BUSM_FIXED_PRIO_EN
  // Round-robin pointer moves past the thread just granted.
  always_comb begin
    ptr_d = accept ? ~tid_q : ptr_q;
  end
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= StIdle;
      tid_q   <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
`ifndef RV_LSU_BUSM_FIXED_PRIO_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tid_q   <= tid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
`ifndef RV_LSU_BUSM_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.req_gnt        = gnt;
  assign bus.busm_cmd_vld   = (state_q == StCmd);
  assign bus.busm_cmd_tid   = tid_q;
  assign bus.busm_cmd_tag   = tag_q;
  assign bus.outs_cnt       = cnt_q;
  assign bus.busm_clken_req = (state_q == StCmd) | (|bus.req_vld) | (|cnt_q) |
                              (|bus.dec_tlu_force_halt_bus);

endmodule

// File: doc/eh2_lsu_busm_arb.md
EH2_LSU_BUSM_ARB -- requirements
Module: eh2_lsu_busm_arb

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 2, number of requesting threads (1 or 2).
REQ-002 SHALL have parameter TAGW, default 3, bus buffer entry tag width.
REQ-003 SHALL have parameter MAX_OUTS, default 4, max outstanding commands per thread (1..7).
REQ-004 SHALL use one clock and a synchronous active-low reset.
REQ-005 SHALL have ports:
- clk  in  1  core clock
- rst_l  in  1  synchronous active-low reset
- lsu_bus_clk_en  in  1  bus clock enable; bus-side events count only when high
- req_vld  in  NUM_THREADS  per-thread command request from bus buffer
- req_tag  in  NUM_THREADS x TAGW  per-thread command tag
- dec_tlu_force_halt_bus  in  NUM_THREADS  bus-synchronized force halt
- busm_cmd_rdy  in  1  bus accepts command
- busm_rsp_vld  in  1  bus response returned
- busm_rsp_tid  in  1  thread of response
- req_gnt  out  NUM_THREADS  one-hot, thread's command accepted this cycle
- busm_cmd_vld  out  1  command valid to bus
- busm_cmd_tid  out  1  thread of command
- busm_cmd_tag  out  TAGW  tag of command
- busm_clken_req  out  1  request to keep lsu_busm clock running
- outs_cnt  out  NUM_THREADS x 3  per-thread outstanding count

Function
REQ-006 SHALL implement states IDLE, CMD (command presented), HALT.
REQ-007 Thread t eligible iff req_vld[t] & ~dec_tlu_force_halt_bus[t] & outs_cnt[t] < MAX_OUTS.
REQ-008 IDLE: on lsu_bus_clk_en with >=1 eligible thread, SHALL select winner by round-robin pointer, register tid/tag, go to CMD next cycle.
REQ-009 CMD: busm_cmd_vld=1; tid/tag SHALL stay stable until acceptance (lsu_bus_clk_en & busm_cmd_rdy).
REQ-010 On acceptance: req_gnt[tid] pulses one cycle, outs_cnt[tid] +1, pointer moves to other thread, return to IDLE.
REQ-011 Force halt on the thread held in CMD SHALL NOT drop busm_cmd_vld; the command completes normally.
REQ-012 busm_rsp_vld & lsu_bus_clk_en SHALL decrement outs_cnt[busm_rsp_tid]; decrement at 0 saturates at 0.
REQ-013 Same-cycle increment and decrement of one thread SHALL leave the count unchanged.
REQ-014 All dec_tlu_force_halt_bus bits high in IDLE SHALL enter HALT; HALT exits to IDLE when any halt bit clears.
REQ-015 Thread in force halt with zero outstanding SHALL hold outs_cnt at 0; nonzero counts drain via responses only.
REQ-016 busm_clken_req = (busm_cmd_vld | any req_vld | any outs_cnt != 0 | any force halt), combinational.
REQ-017 Arbitration latency: eligible request on an enabled cycle to busm_cmd_vld SHALL be exactly 1 cycle.
REQ-018 NUM_THREADS=1: pointer unused; busm_cmd_tid always 0.

Reset
REQ-019 rst_l low at clk edge SHALL force: state IDLE, pointer thread 0, outs_cnt 0, busm_cmd_vld 0, req_gnt 0, busm_cmd_tid 0, busm_cmd_tag 0.
REQ-020 Reset in CMD SHALL drop the pending command without granting.

Configuration
REQ-021 Macro RV_LSU_BUSM_FIXED_PRIO_EN defined: thread 0 SHALL always win when both eligible; pointer removed.
REQ-022 Macro undefined: round-robin per REQ-008/REQ-010.

Verification
REQ-023 Both threads req_vld=1, clk_en=1, rdy=1 continuously -> gnt alternates t0,t1,t0,t1 (fixed prio: t0 only until outs_cnt[0]=MAX_OUTS=4, then t1).
REQ-024 t0 req, rdy=0 for 5 cycles, tag=5 -> busm_cmd_vld held, tag stays 5, no gnt until rdy=1, then gnt[0] one cycle.
REQ-025 t0 issues 4 cmds with no responses -> outs_cnt[0]=4, t0 ineligible; one rsp tid=0 -> count 3, t0 granted again.
REQ-026 Accept t1 cmd and rsp tid=1 in same enabled cycle with outs_cnt[1]=2 -> outs_cnt[1] stays 2.
REQ-027 lsu_bus_clk_en high every 3rd cycle -> acceptance and response counting only on enabled cycles.
REQ-028 Force halt t0 during CMD for t0 -> cmd completes, no further t0 grants; all halts high -> HALT, release -> IDLE.
